ysyx_24090003_wbarb: RTL and testbench

YSYX_24090003_WBARB -- requirements
Module: ysyx_24090003_wbarb

---
 rtl/ysyx_24090003_wbarb.sv | 91 +++++++++
 tb/tb_ysyx_24090003_wbarb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090003_wbarb.sv
// Write-back arbiter: round-robin EXU/LSU onto the single register-file write port, 1-cycle registered output.
// Optional pending-write scoreboard is built only when YSYX_24090003_SCOREBOARD_EN is defined.
module ysyx_24090003_wbarb #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              ex_valid,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  output logic              ex_ready,
  input  logic              ls_valid,
  input  logic [RD_W-1:0]   ls_rd,
  input  logic [DATA_W-1:0] ls_data,
  output logic              ls_ready,
  output logic              wb_en,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic              issue_valid,
  input  logic [RD_W-1:0]   issue_rd,
  input  logic [RD_W-1:0]   rs1,
  input  logic [RD_W-1:0]   rs2,
  output logic              rs1_busy,
  output logic              rs2_busy
);
  localparam int NREG = 1 << RD_W;

  logic              r_ptr;
  logic              w_ex_gnt;
  logic              w_ls_gnt;
  logic              w_accept;
  logic [RD_W-1:0]   w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;

  // The pointer only decides ties; 0 prefers EXU. Nothing is accepted while in reset.
  assign w_ex_gnt   = !cpu_rst && ex_valid && (!ls_valid || !r_ptr);
  assign w_ls_gnt   = !cpu_rst && ls_valid && (!ex_valid || r_ptr);
  assign w_accept   = w_ex_gnt || w_ls_gnt;
  assign w_sel_rd   = w_ls_gnt ? ls_rd : ex_rd;
  assign w_sel_data = w_ls_gnt ? ls_data : ex_data;
  assign ex_ready   = w_ex_gnt;
  assign ls_ready   = w_ls_gnt;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      r_ptr   <= 1'b0;
    end else begin
      // An x0 write still wins the grant and moves the pointer, but never reaches the regfile.
      wb_en <= w_accept && (w_sel_rd != '0);
      if (w_accept) begin
        wb_rd   <= w_sel_rd;
        wb_data <= w_sel_data;
        r_ptr   <= w_ex_gnt;
      end
    end
  end

`ifdef YSYX_24090003_SCOREBOARD_EN
  localparam logic [NREG-1:0] ONE = NREG'(1);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  assign w_set = (issue_valid && (issue_rd != '0)) ? (ONE << issue_rd) : '0;
  assign w_clr = wb_en ? (ONE << wb_rd) : '0;

  // Set is applied after clear so a new producer outranks the retiring one.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~ONE;
    end
  end

  assign rs1_busy = r_busy[rs1];
  assign rs2_busy = r_busy[rs2];
`else
  logic w_unused_sb;

  assign w_unused_sb = ^{issue_valid, issue_rd, rs1, rs2, NREG[0]};
  assign rs1_busy    = 1'b0;
  assign rs2_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24090003_wbarb.sv
// Bench for the write-back arbiter: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_ysyx_24090003_wbarb;
  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        ex_valid, ls_valid, ex_ready, ls_ready;
  logic [4:0]  ex_rd, ls_rd, wb_rd, issue_rd, rs1, rs2;
  logic [31:0] ex_data, ls_data, wb_data;
  logic        wb_en, issue_valid, rs1_busy, rs2_busy;

  always #5 cpu_clk = ~cpu_clk;

  ysyx_24090003_wbarb #(.DATA_W(32), .RD_W(5)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .ls_valid(ls_valid), .ls_rd(ls_rd), .ls_data(ls_data), .ls_ready(ls_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what the registered outputs must show now, which side wins ties, pending writes.
  logic        m_wb_en;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;
  logic        m_prefer_ls;
  bit   [31:0] m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called once inputs have settled; compares everything, advances the model, returns the winner
  // (0 none, 1 EXU, 2 LSU) and ends at the next falling edge.
  task automatic step(output int who);
    logic        e_b1, e_b2;
    logic [4:0]  rd;
    logic [31:0] dat;
    if (cpu_rst) who = 0;
    else if (ex_valid && ls_valid) who = m_prefer_ls ? 2 : 1;
    else if (ex_valid) who = 1;
    else if (ls_valid) who = 2;
    else who = 0;
`ifdef YSYX_24090003_SCOREBOARD_EN
    e_b1 = (rs1 != 5'd0) && m_busy[rs1];
    e_b2 = (rs2 != 5'd0) && m_busy[rs2];
`else
    e_b1 = 1'b0;
    e_b2 = 1'b0;
`endif
    chk("ex_ready", 32'(ex_ready), 32'(who == 1));
    chk("ls_ready", 32'(ls_ready), 32'(who == 2));
    chk("wb_en", 32'(wb_en), 32'(m_wb_en));
    chk("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
    chk("wb_data", wb_data, m_wb_data);
    chk("rs1_busy", 32'(rs1_busy), 32'(e_b1));
    chk("rs2_busy", 32'(rs2_busy), 32'(e_b2));
    if (cpu_rst) begin
      m_wb_en = 1'b0; m_wb_rd = '0; m_wb_data = '0; m_prefer_ls = 1'b0; m_busy = '0;
    end else begin
      if (m_wb_en) m_busy[m_wb_rd] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      if (who != 0) begin
        rd  = (who == 1) ? ex_rd : ls_rd;
        dat = (who == 1) ? ex_data : ls_data;
        m_wb_en = (rd != 5'd0);
        m_wb_rd = rd;
        m_wb_data = dat;
        m_prefer_ls = (who == 1);
      end else begin
        m_wb_en = 1'b0;
      end
    end
    @(negedge cpu_clk);
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ls_valid = 0; issue_valid = 0;
    ex_rd = 0; ls_rd = 0; ex_data = 0; ls_data = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic do_reset(input int cycles);
    int w;
    cpu_rst = 1;
    for (int i = 0; i < cycles; i++) begin
      #1; step(w);
    end
    cpu_rst = 0;
  endtask

  initial begin
    int   w;
    int   exp_g[4];
    logic ex_pend, ls_pend;

    idle_inputs();
    cpu_rst = 1;
    @(negedge cpu_clk);
    m_wb_en = 0; m_wb_rd = 0; m_wb_data = 0; m_prefer_ls = 0; m_busy = '0;
    // A request seen in reset must not be taken.
    ex_valid = 1; ex_rd = 5'd3; ex_data = 32'h55;
    #1; chk("rst_ex_ready", 32'(ex_ready), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    step(w);
    cpu_rst = 0;

    // Single EXU write.
    ex_valid = 1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
    #1; chk("s1_ex_ready", 32'(ex_ready), 32'd1);
    chk("s1_no_write_after_rst", 32'(wb_en), 32'd0);
    step(w);
    ex_valid = 0;
    #1; chk("s1_wb_en", 32'(wb_en), 32'd1);
    chk("s1_wb_rd", 32'(wb_rd), 32'd5);
    chk("s1_wb_data", wb_data, 32'hDEADBEEF);
    step(w);

    // Both requesters busy for four cycles straight out of reset.
    idle_inputs();
    do_reset(2);
    exp_g[0] = 1; exp_g[1] = 2; exp_g[2] = 1; exp_g[3] = 2;
    ex_valid = 1; ls_valid = 1; ex_rd = 5'd10; ls_rd = 5'd20; ex_data = 32'hE0; ls_data = 32'hA0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i >= 1) chk("s2_wb_en", 32'(wb_en), 32'd1);
      step(w);
      chk("s2_grant", 32'(w), 32'(exp_g[i]));
      if (w == 1) begin ex_rd = ex_rd + 5'd1; ex_data = ex_data + 32'd1; end
      if (w == 2) begin ls_rd = ls_rd + 5'd1; ls_data = ls_data + 32'd1; end
    end
    idle_inputs();
    #1; chk("s2_last_wb_en", 32'(wb_en), 32'd1);
    chk("s2_last_wb_rd", 32'(wb_rd), 32'd21);
    step(w);

    // x0 write from LSU: grant consumed, no write, tie goes back to EXU.
    ex_valid = 1; ex_rd = 5'd4; ex_data = 32'h44;
    #1; step(w);
    ex_valid = 0; ls_valid = 1; ls_rd = 5'd0; ls_data = 32'h1234;
    #1; chk("s3_ls_ready", 32'(ls_ready), 32'd1);
    step(w);
    ex_valid = 1; ex_rd = 5'd6; ls_valid = 1; ls_rd = 5'd8;
    #1; chk("s3_wb_en", 32'(wb_en), 32'd0);
    chk("s3_ptr_exu", 32'(ex_ready), 32'd1);
    step(w);
    idle_inputs();
    #1; step(w);

`ifdef YSYX_24090003_SCOREBOARD_EN
    issue_valid = 1; issue_rd = 5'd7; rs1 = 5'd7;
    #1; chk("s4_busy_before", 32'(rs1_busy), 32'd0);
    step(w);
    issue_valid = 0;
    #1; chk("s4_busy_set", 32'(rs1_busy), 32'd1);
    step(w);
    ex_valid = 1; ex_rd = 5'd7; ex_data = 32'h77;
    #1; step(w);
    ex_valid = 0;
    #1; chk("s4_busy_during_wb", 32'(rs1_busy), 32'd1);
    step(w);
    #1; chk("s4_busy_cleared", 32'(rs1_busy), 32'd0);
    step(w);
    issue_valid = 1; issue_rd = 5'd7;
    #1; step(w);
    issue_valid = 0; ex_valid = 1; ex_rd = 5'd7;
    #1; step(w);
    ex_valid = 0; issue_valid = 1; issue_rd = 5'd7;
    #1; chk("s4_same_cycle_wb", 32'(wb_en), 32'd1);
    step(w);
    issue_valid = 0;
    #1; chk("s4_newer_wins", 32'(rs1_busy), 32'd1);
    step(w);
`else
    issue_valid = 1; issue_rd = 5'd3; rs2 = 5'd3;
    #1; step(w);
    issue_valid = 0;
    #1; chk("s6_rs2_never_busy", 32'(rs2_busy), 32'd0);
    step(w);
`endif

    // Reset lands right after an EXU accept.
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd9;
    #1; step(w);
    issue_valid = 0; ex_valid = 1; ex_rd = 5'd9; ex_data = 32'h99;
    #1; step(w);
    cpu_rst = 1; ls_valid = 1; ls_rd = 5'd2;
    #1; chk("s5_rst_ex_ready", 32'(ex_ready), 32'd0);
    chk("s5_rst_ls_ready", 32'(ls_ready), 32'd0);
    step(w);
    cpu_rst = 0; rs1 = 5'd9; rs2 = 5'd7;
    #1; chk("s5_wb_en", 32'(wb_en), 32'd0);
    chk("s5_rs1_clear", 32'(rs1_busy), 32'd0);
    chk("s5_rs2_clear", 32'(rs2_busy), 32'd0);
    chk("s5_exu_first", 32'(ex_ready), 32'd1);
    step(w);

    // Random traffic: requests stay up with stable payload until granted.
    idle_inputs();
    ex_pend = 0; ls_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      cpu_rst = ($urandom_range(0, 199) == 0);
      if (!ex_pend && $urandom_range(0, 9) < 6) begin
        ex_pend = 1; ex_rd = 5'($urandom_range(0, 31)); ex_data = $urandom;
      end
      if (!ls_pend && $urandom_range(0, 9) < 5) begin
        ls_pend = 1; ls_rd = 5'($urandom_range(0, 31)); ls_data = $urandom;
      end
      ex_valid = ex_pend; ls_valid = ls_pend;
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rd = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      #1; step(w);
      if (w == 1) ex_pend = 0;
      if (w == 2) ls_pend = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
